// File: rtl/jtcop_obj_dma.sv
// jtcop_obj_dma: copies CPU object RAM into the hidden half of a double-buffered
// object table during vblank, then swaps halves so the drawer sees a stable frame.
module jtcop_obj_dma #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          LVBL,
    input  logic          dma_trig,
    output logic          bus_req,
    input  logic          bus_ack,
    output logic          ram_cs,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_dout,
    input  logic [AW-1:0] tbl_addr,
    output logic [DW-1:0] tbl_dout,
    output logic          busy
);
    typedef enum logic [2:0] {IDLE, REQ, COPY, FLUSH, SWAP} state_t;
    state_t        st;
    logic          bank, pending, wr_en, go, rd, rd_bank;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] mem [0:2**(AW+1)-1];
    assign go      = st == IDLE && (pending || dma_trig) && !LVBL;
    // a word counts only when the strobe was out while the bus was still ours
    assign rd      = st == COPY && ram_cs && bus_ack;
    assign rd_bank = st == SWAP ? ~bank : bank;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            st       <= IDLE;
            bank     <= 1'b0;
            pending  <= 1'b0;
            bus_req  <= 1'b0;
            ram_cs   <= 1'b0;
            ram_addr <= '0;
            busy     <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            tbl_dout <= '0;
        end else begin
            pending  <= !go && (pending || dma_trig);
            wr_en    <= rd;
            wr_addr  <= ram_addr;
            tbl_dout <= mem[{rd_bank, tbl_addr}];
            case (st)
                IDLE: if (go) begin
                    st      <= REQ;
                    bus_req <= 1'b1;
                    busy    <= 1'b1;
                end
                REQ: if (bus_ack) begin
                    st       <= COPY;
                    ram_cs   <= 1'b1;
                    ram_addr <= '0;
                end
                COPY: begin
                    ram_addr <= ram_addr + AW'(rd);
                    if (rd && &ram_addr) begin
                        st      <= FLUSH;
                        ram_cs  <= 1'b0;
                        bus_req <= 1'b0;
                    end else ram_cs <= bus_ack;
                end
                FLUSH: st <= SWAP;
                SWAP: begin
                    bank <= ~bank;
                    busy <= 1'b0;
                    st   <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    always_ff @(posedge clk)
        if (wr_en) mem[{~bank, wr_addr}] <= ram_dout;
endmodule
